// File: rtl/peridot_uart_rxd.sv
// 8N1 UART receiver -> Avalon-ST bytes; push 1 cycle after stop sample, out_data held while stalled.
// PERIDOT_UART_RXD_FIFO_EN selects a FWFT ring of 2^FIFO_DEPTH_LOG2 bytes, else one holding register (full -> overrun pulse).
module peridot_uart_rxd #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int UART_BAUDRATE   = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       framing_error,
  output logic       overrun
);

  localparam int BIT_CYCLE  = CLOCK_FREQUENCY / UART_BAUDRATE;
  localparam int HALF_CYCLE = BIT_CYCLE / 2;
  localparam int CNT_W      = (BIT_CYCLE < 4) ? 2 : $clog2(BIT_CYCLE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLE - 1);

  localparam logic [2:0] WAIT_HIGH = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  generate
    if (BIT_CYCLE < 4) begin : g_bad_rate
      $error("peridot_uart_rxd: CLOCK_FREQUENCY/UART_BAUDRATE must be at least 4");
    end
  endgenerate

  logic             r_rxd_meta;
  logic             r_rxd_s;
  logic [1:0]       r_sync_fill;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shreg;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_bit_done;
  logic             w_half_done;
  logic             w_push;
  logic             w_pop;

  assign w_bit_done  = (r_cnt == BIT_LAST);
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_push      = (r_state == STOP) && w_bit_done && r_rxd_s;

  // The synchronizer resets high, so WAIT_HIGH also waits until both stages hold
  // a real line sample; otherwise a line held low across reset would look idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_s     <= 1'b1;
      r_sync_fill <= 2'b00;
      r_state     <= WAIT_HIGH;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_ferr      <= 1'b0;
    end else begin
      r_rxd_meta  <= rxd;
      r_rxd_s     <= r_rxd_meta;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
      r_ferr      <= 1'b0;
      case (r_state)
        WAIT_HIGH: if (r_sync_fill[1] && r_rxd_s) r_state <= IDLE;
        IDLE: begin
          if (!r_rxd_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            if (r_rxd_s) begin
              r_state <= IDLE;
            end else begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_shreg  <= {r_rxd_s, r_shreg[7:1]};
            r_cnt    <= '0;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_rxd_s) begin
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

`ifdef PERIDOT_UART_RXD_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  generate
    if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_depth
      $error("peridot_uart_rxd: FIFO_DEPTH_LOG2 must be at least 1");
    end
  endgenerate

  logic [7:0]             r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] r_rd_ptr;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_DEPTH_LOG2] != r_rd_ptr[FIFO_DEPTH_LOG2]) &&
                   (r_wr_ptr[FIFO_DEPTH_LOG2-1:0] == r_rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees the head slot this cycle, so a push into a full ring still lands.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ovr <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= r_shreg;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
`else
  generate
    if (FIFO_DEPTH_LOG2 < 0) begin : g_bad_depth
      $error("peridot_uart_rxd: FIFO_DEPTH_LOG2 must not be negative");
    end
  endgenerate

  logic       r_valid;
  logic [7:0] r_hold;

  assign w_pop = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_hold  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_push && r_valid && !w_pop;
      if (w_push && (!r_valid || w_pop)) begin
        r_hold  <= r_shreg;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_hold;
`endif

  assign framing_error = r_ferr;
  assign overrun       = r_ovr;

endmodule
